// File: rtl/noc_input_buffer.sv
// Per-port router input FIFO with head-of-queue arbiter interface and write-side packet framing check.
// Optional framing FSM and sticky error flag are enabled by defining NOC_INBUF_FRAMECHK_EN.
module noc_input_buffer #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2:0]              in_flit_id,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    full,
    input  logic                    grant,
    output logic                    req,
    output logic [2:0]              flit_id,
    output logic [11:0]             length,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    err,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_BODY = 3'b010;
    localparam logic [2:0] ID_TAIL = 3'b100;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [2:0]            id_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic [11:0]      len_q, len_d;

    logic frame_ok;
    logic accept;
    logic pop;
    logic head_is_hdr;

`ifdef NOC_INBUF_FRAMECHK_EN
    typedef enum logic {
        WR_IDLE,
        WR_PKT
    } wr_state_e;

    wr_state_e state_q, state_d;
    logic      err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WR_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Flits turned away by a full FIFO are not judged, so they neither move the FSM nor flag an error.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        frame_ok = 1'b0;
        if (in_valid && !full_q) begin
            case (state_q)
                WR_IDLE: begin
                    if (in_flit_id == ID_HEAD) begin
                        frame_ok = 1'b1;
                        state_d  = WR_PKT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                WR_PKT: begin
                    if (in_flit_id == ID_BODY) begin
                        frame_ok = 1'b1;
                    end else if (in_flit_id == ID_TAIL) begin
                        frame_ok = 1'b1;
                        state_d  = WR_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = WR_IDLE;
                end
            endcase
        end
    end

    assign err = err_q;
`else
    assign frame_ok = 1'b1;
    assign err      = 1'b0;
`endif

    assign accept = in_valid && !full_q && frame_ok;
    assign req    = (count_q != '0);
    assign pop    = grant && req;

    assign flit_id     = req ? id_mem[rd_ptr_q]   : 3'b000;
    assign out_data    = req ? data_mem[rd_ptr_q] : '0;
    assign head_is_hdr = (flit_id == ID_HEAD);

    // A header at the head drives length directly so the arbiter timer sees it in the grant cycle.
    assign length = head_is_hdr ? out_data[11:0] : len_q;
    assign full   = full_q;
    assign count  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (head_is_hdr) begin
                len_d = out_data[11:0];
            end
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            len_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            len_q    <= len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr_q] <= in_data;
            id_mem[wr_ptr_q]   <= in_flit_id;
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Randomized and directed bench for noc_input_buffer against a queue-based packet model.
// Follows NOC_INBUF_FRAMECHK_EN the same way the design does.
module tb_noc_input_buffer;

    localparam int DEPTH      = 8;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    localparam logic [2:0] HEAD = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic [2:0]            in_flit_id;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  full;
    logic                  grant;
    logic                  req;
    logic [2:0]            flit_id;
    logic [11:0]           length;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  err;
    logic [CNT_W-1:0]      count;

    noc_input_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit_id (in_flit_id),
        .in_data    (in_data),
        .full       (full),
        .grant      (grant),
        .req        (req),
        .flit_id    (flit_id),
        .length     (length),
        .out_data   (out_data),
        .err        (err),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]            id;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    flit_t       modelQ[$];
    bit          modelErr;
    bit          modelInPkt;
    logic [11:0] modelLen;

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic compareAll();
        flit_t       head;
        logic [11:0] expLen;
        bit          nonEmpty;
        nonEmpty = (modelQ.size() > 0);
        head.id   = 3'b000;
        head.data = '0;
        if (nonEmpty) head = modelQ[0];
        expLen = (nonEmpty && head.id == HEAD) ? head.data[11:0] : modelLen;
        checkOutput("req",      64'(req),      64'(nonEmpty));
        checkOutput("flit_id",  64'(flit_id),  64'(head.id));
        checkOutput("out_data", 64'(out_data), 64'(head.data));
        checkOutput("length",   64'(length),   64'(expLen));
        checkOutput("count",    64'(count),    64'(modelQ.size()));
        checkOutput("full",     64'(full),     64'(modelQ.size() == DEPTH));
        checkOutput("err",      64'(err),      64'(modelErr));
    endtask

    function automatic bit frameLegal(input logic [2:0] id);
`ifdef NOC_INBUF_FRAMECHK_EN
        if (modelInPkt) return (id == BODY) || (id == TAIL);
        return (id == HEAD);
`else
        return 1'b1;
`endif
    endfunction

    // One clock period: drive, check pre-edge outputs, then advance the model across the edge.
    task automatic applyStimulus(input logic v, input logic [2:0] id, input logic [DATA_WIDTH-1:0] data, input logic g);
        bit    doAccept;
        bit    doPop;
        flit_t f;
        in_valid   = v;
        in_flit_id = id;
        in_data    = data;
        grant      = g;
        #1;
        compareAll();
        doAccept = 1'b0;
        if (v && modelQ.size() < DEPTH) begin
            if (frameLegal(id)) begin
                doAccept = 1'b1;
                if (id == HEAD) modelInPkt = 1'b1;
                if (id == TAIL) modelInPkt = 1'b0;
            end else begin
                modelErr = 1'b1;
            end
        end
        doPop = g && (modelQ.size() > 0);
        @(posedge clk);
        if (doPop) begin
            if (modelQ[0].id == HEAD) modelLen = modelQ[0].data[11:0];
            void'(modelQ.pop_front());
        end
        if (doAccept) begin
            f.id   = id;
            f.data = data;
            modelQ.push_back(f);
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_flit_id = 3'b000;
        in_data    = '0;
        grant      = 1'b0;
        modelQ.delete();
        modelErr   = 1'b0;
        modelInPkt = 1'b0;
        modelLen   = '0;
        #1;
        compareAll();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain();
        repeat (DEPTH + 1) applyStimulus(1'b0, 3'b000, '0, 1'b1);
    endtask

    function automatic logic [DATA_WIDTH-1:0] rnd();
        return DATA_WIDTH'($urandom);
    endfunction

    function automatic logic [2:0] pickId();
        logic [2:0] illegal [3];
        illegal[0] = 3'b011;
        illegal[1] = 3'b000;
        illegal[2] = 3'b111;
        if ($urandom_range(0, 9) == 0) return illegal[$urandom_range(0, 2)];
        if ($urandom_range(0, 9) == 0) return HEAD;
        if (!modelInPkt) return HEAD;
        return ($urandom_range(0, 2) == 0) ? TAIL : BODY;
    endfunction

    initial begin
        logic [DATA_WIDTH-1:0] hdr;
        doReset();

        // Single packet of length 5, then pop it with length held.
        hdr = {rnd() >> 12, 12'h005};
        applyStimulus(1'b1, HEAD, hdr,   1'b0);
        applyStimulus(1'b1, BODY, rnd(), 1'b0);
        applyStimulus(1'b1, TAIL, rnd(), 1'b0);
        checkOutput("pktCount", 64'(count),   64'd3);
        checkOutput("pktReq",   64'(req),     64'd1);
        checkOutput("pktId",    64'(flit_id), 64'(HEAD));
        checkOutput("pktLen",   64'(length),  64'h005);
        for (int i = 0; i < 3; i++) begin
            checkOutput("pktLenHold", 64'(length), 64'h005);
            applyStimulus(1'b0, 3'b000, '0, 1'b1);
        end
        checkOutput("pktLenAfter", 64'(length), 64'h005);
        checkOutput("pktReqAfter", 64'(req),    64'd0);

        // Fill to DEPTH, try to overfill, then pop with a simultaneous write.
        applyStimulus(1'b1, HEAD, rnd(), 1'b0);
        for (int i = 0; i < DEPTH - 2; i++) applyStimulus(1'b1, BODY, rnd(), 1'b0);
        applyStimulus(1'b1, TAIL, rnd(), 1'b0);
        checkOutput("fullSet", 64'(full), 64'd1);
        applyStimulus(1'b1, HEAD, rnd(), 1'b0);
        checkOutput("fullCount", 64'(count), 64'(DEPTH));
        applyStimulus(1'b1, HEAD, rnd(), 1'b1);
        checkOutput("fullPopWrite", 64'(count), 64'(DEPTH - 1));
        drain();

        // Continuous streaming across several pointer wraps.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            logic [2:0] id;
            id = (i % 4 == 0) ? HEAD : ((i % 4 == 3) ? TAIL : BODY);
            applyStimulus(1'b1, id, rnd(), 1'b1);
            checkOutput("wrapCount", 64'(count <= 2), 64'd1);
        end
        drain();

        // Header, header, tail.
        applyStimulus(1'b1, HEAD, rnd(), 1'b0);
        applyStimulus(1'b1, HEAD, rnd(), 1'b0);
        applyStimulus(1'b1, TAIL, rnd(), 1'b0);
`ifdef NOC_INBUF_FRAMECHK_EN
        checkOutput("frameCount", 64'(count), 64'd2);
        checkOutput("frameErr",   64'(err),   64'd1);
`else
        checkOutput("frameCount", 64'(count), 64'd3);
        checkOutput("frameErr",   64'(err),   64'd0);
`endif
        drain();

        // Reset in the middle of a packet; the next body must be rejected.
        applyStimulus(1'b1, HEAD, rnd(), 1'b0);
        applyStimulus(1'b1, BODY, rnd(), 1'b0);
        doReset();
        checkOutput("rstCount", 64'(count), 64'd0);
        applyStimulus(1'b1, BODY, rnd(), 1'b0);
`ifdef NOC_INBUF_FRAMECHK_EN
        checkOutput("rstBodyCount", 64'(count), 64'd0);
        checkOutput("rstBodyErr",   64'(err),   64'd1);
`else
        checkOutput("rstBodyCount", 64'(count), 64'd1);
        checkOutput("rstBodyErr",   64'(err),   64'd0);
`endif

        // Illegal flit id from a clean start.
        doReset();
        applyStimulus(1'b1, 3'b011, rnd(), 1'b0);
`ifdef NOC_INBUF_FRAMECHK_EN
        checkOutput("illegalCount", 64'(count), 64'd0);
        checkOutput("illegalErr",   64'(err),   64'd1);
`else
        checkOutput("illegalCount", 64'(count), 64'd1);
        checkOutput("illegalErr",   64'(err),   64'd0);
`endif

        // Random traffic with random grants and an occasional reset.
        doReset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            applyStimulus(1'($urandom_range(0, 3) != 0), pickId(), rnd(), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
